lsu_param: RTL
==============

LSU_PARAM -- requirements
Module: lsu_param

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 8, memory address width.
REQ-002 The block SHALL have parameter DATA_BITS, default 8, register and memory data width.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 255, WAITING-cycle limit; it is used only with LSU_TIMEOUT_EN.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port enable, input, 1 bit: thread active; when low, all state and outputs hold.
REQ-007 The block SHALL have port core_state, input, 3 bits: core phase; REQUEST=3'b011, WAIT=3'b101, UPDATE=3'b110.
REQ-008 The block SHALL have ports mem_read_enable and mem_write_enable, inputs, 1 bit each: decoded LDR/STR.
REQ-009 The block SHALL have port rs_out, input, DATA_BITS: address operand.
REQ-010 The block SHALL have port rt_out, input, DATA_BITS: store data.
REQ-011 The block SHALL have read-channel ports: mem_read_valid (out, 1), mem_read_address (out, ADDR_BITS), mem_read_ready (in, 1), mem_read_data (in, DATA_BITS).
REQ-012 The block SHALL have write-channel ports: mem_write_valid (out, 1), mem_write_address (out, ADDR_BITS), mem_write_data (out, DATA_BITS), mem_write_ready (in, 1).
REQ-013 The block SHALL have port lsu_out, output, DATA_BITS: last loaded value.
REQ-014 The block SHALL have port lsu_state, output, 2 bits: FSM state.
REQ-015 The block SHALL have port lsu_error, output, 1 bit: timeout flag.

Function
REQ-016 lsu_state SHALL encode IDLE=0, REQUESTING=1, WAITING=2, DONE=3.
REQ-017 IDLE SHALL go to REQUESTING when core_state==REQUEST and either enable bit is set; if both are set, the operation is a read and the write is ignored.
REQ-018 On leaving IDLE, the address SHALL be captured from rs_out: low ADDR_BITS bits if DATA_BITS>=ADDR_BITS, otherwise zero-extended; for stores, write data is also captured from rt_out.
REQ-019 REQUESTING SHALL assert the selected channel's valid with the captured address (and data), then go to WAITING on the next cycle.
REQ-020 In WAITING, valid SHALL stay high until the matching ready is sampled high; on that edge valid drops, the FSM goes to DONE, and a read loads mem_read_data into lsu_out.
REQ-021 Ready inputs SHALL be ignored outside WAITING, and the opposite channel's ready SHALL be ignored in WAITING.
REQ-022 Minimum latency SHALL be 3 cycles: REQUEST edge, then valid, then ready sampled, then DONE.
REQ-023 DONE SHALL return to IDLE when core_state==UPDATE, and hold otherwise.
REQ-024 Changes to core_state while in REQUESTING or WAITING SHALL NOT abort the transaction.
REQ-025 lsu_out SHALL change only on read completion, and address/data outputs SHALL hold their last values when valid is low.
REQ-026 With enable low, the FSM, counter and all outputs SHALL freeze, including a valid that is already high.

Reset
REQ-027 When reset is high at a clock edge, the block SHALL set lsu_state=IDLE, both valids=0, addresses=0, write data=0, lsu_out=0, lsu_error=0 and the counter=0, regardless of enable.
REQ-028 Reset asserted mid-transaction SHALL drop valid at the same edge, with no completion and no lsu_out update.

Configuration
REQ-029 With macro LSU_TIMEOUT_EN defined, an ADDR_BITS-independent counter SHALL count the enabled cycles spent in WAITING.
REQ-030 With LSU_TIMEOUT_EN defined, if the count reaches TIMEOUT_CYCLES without ready, the block SHALL drop valid, set lsu_error, go to DONE and leave lsu_out unchanged.
REQ-031 With LSU_TIMEOUT_EN defined, a ready arriving on the same cycle the limit is reached SHALL win: normal completion and no error.
REQ-032 With LSU_TIMEOUT_EN defined, lsu_error SHALL be sticky until reset or the next accepted request, and the counter SHALL clear on entering WAITING.
REQ-033 Without LSU_TIMEOUT_EN, there SHALL be no counter, lsu_error SHALL be constant 0 and WAITING SHALL wait indefinitely.

Verification
REQ-034 Load case: rs_out=0x0A, mem_read_data=0xAB, ready one cycle after valid -> mem_read_address=0x0A while valid; lsu_out=0xAB in DONE; IDLE after UPDATE.
REQ-035 Store case: rs_out=0x0C, rt_out=0x55 -> mem_write_address=0x0C and mem_write_data=0x55 while valid; lsu_out unchanged.
REQ-036 Both enables set, rs_out=0x10 -> only mem_read_valid asserts; mem_write_valid stays 0 throughout.
REQ-037 Parameter case, DATA_BITS=16 and ADDR_BITS=8, rs_out=0x1234 -> mem_read_address=0x34; load of 0xBEEF gives lsu_out=0xBEEF.
REQ-038 Reset asserted while in WAITING -> next edge shows lsu_state=0 and valid=0; a later ready causes no state change.
REQ-039 With LSU_TIMEOUT_EN defined and TIMEOUT_CYCLES=4, no ready -> valid drops after 4 WAITING cycles, lsu_error=1 and lsu_state=3; with ready on cycle 4 -> lsu_error=0.

Source files
------------

// File: rtl/lsu_param.sv
// Load/store unit: one outstanding memory access per request, valid/ready channels.
// Optional WAITING timeout enabled by defining LSU_TIMEOUT_EN.
module lsu_param #(
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic                 mem_read_enable,
  input  logic                 mem_write_enable,
  input  logic [DATA_BITS-1:0] rs_out,
  input  logic [DATA_BITS-1:0] rt_out,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data,
  input  logic                 mem_write_ready,
  output logic [DATA_BITS-1:0] lsu_out,
  output logic [1:0]           lsu_state,
  output logic                 lsu_error
);

  // Handshake: valid rises on entry to WAITING and stays high with stable
  // address/data until the selected channel's ready is sampled high at a
  // clock edge; transfer happens on that edge and valid drops with it.

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    REQUESTING = 2'd1,
    WAITING    = 2'd2,
    DONE       = 2'd3
  } state_t;

  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;

  state_t               state_q, state_d;
  logic                 is_read_q, is_read_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 wr_valid_q, wr_valid_d;
  logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_BITS-1:0] wr_data_q, wr_data_d;
  logic [DATA_BITS-1:0] lsu_out_q, lsu_out_d;
  logic [ADDR_BITS-1:0] cap_addr;
  logic                 ready_sel;

  if (DATA_BITS >= ADDR_BITS) begin : g_trunc
    assign cap_addr = rs_out[ADDR_BITS-1:0];
    if (DATA_BITS > ADDR_BITS) begin : g_hi
      logic unused_rs_hi;
      assign unused_rs_hi = ^rs_out[DATA_BITS-1:ADDR_BITS];
    end
  end else begin : g_zext
    assign cap_addr = {{(ADDR_BITS-DATA_BITS){1'b0}}, rs_out};
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             err_q, err_d;
  assign cnt_inc   = cnt_q + 1'b1;
  assign lsu_error = err_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign lsu_error = 1'b0;
`endif

  assign ready_sel = is_read_q ? mem_read_ready : mem_write_ready;

  always_comb begin
    state_d    = state_q;
    is_read_d  = is_read_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_valid_d = rd_valid_q;
    wr_valid_d = wr_valid_q;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    lsu_out_d  = lsu_out_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = err_q;
`endif
    if (enable) begin
      case (state_q)
        IDLE: begin
          if (core_state == CORE_REQUEST && (mem_read_enable || mem_write_enable)) begin
            state_d   = REQUESTING;
            is_read_d = mem_read_enable;
            addr_d    = cap_addr;
            if (!mem_read_enable) wdata_d = rt_out;
`ifdef LSU_TIMEOUT_EN
            err_d     = 1'b0;
`endif
          end
        end
        REQUESTING: begin
          state_d = WAITING;
          if (is_read_q) begin
            rd_valid_d = 1'b1;
            rd_addr_d  = addr_q;
          end else begin
            wr_valid_d = 1'b1;
            wr_addr_d  = addr_q;
            wr_data_d  = wdata_q;
          end
`ifdef LSU_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
        WAITING: begin
          if (ready_sel) begin
            state_d    = DONE;
            rd_valid_d = 1'b0;
            wr_valid_d = 1'b0;
            if (is_read_q) lsu_out_d = mem_read_data;
          end else begin
`ifdef LSU_TIMEOUT_EN
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
              state_d    = DONE;
              rd_valid_d = 1'b0;
              wr_valid_d = 1'b0;
              err_d      = 1'b1;
            end
`endif
          end
        end
        DONE: begin
          if (core_state == CORE_UPDATE) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      is_read_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_valid_q <= 1'b0;
      wr_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      lsu_out_q  <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      is_read_q  <= is_read_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_valid_q <= rd_valid_d;
      wr_valid_q <= wr_valid_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      lsu_out_q  <= lsu_out_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign mem_read_valid    = rd_valid_q;
  assign mem_read_address  = rd_addr_q;
  assign mem_write_valid   = wr_valid_q;
  assign mem_write_address = wr_addr_q;
  assign mem_write_data    = wr_data_q;
  assign lsu_out           = lsu_out_q;
  assign lsu_state         = state_q;

endmodule
